// File: rtl/instr_boot_loader.sv
// -----------------------------------------------------------------------------
// instr_boot_loader
//
// Receives a program over a UART 8N1 line and writes it word by word into the
// processor's instruction memory. The processor is held in reset until the
// whole program has been written.
//
// Stream format: LEN_HI LEN_LO, then N words sent as HI LO byte pairs.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   rx_in         UART serial input (idle high, asynchronous to clk)
//   instr_wr_en   one-cycle instruction-memory write strobe
//   instr_wr_addr instruction-memory write address
//   instr_wr_data instruction-memory write data
//   cpu_reset_n   active-low reset to the processor, released once loaded
//   busy          high while the word payload is being received
//   done          sticky, load completed
//   frame_err     sticky, bad stop bit or illegal length
// -----------------------------------------------------------------------------
module instr_boot_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 16,
  parameter int MAX_WORDS    = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  output logic              instr_wr_en,
  output logic [ADDR_W-1:0] instr_wr_addr,
  output logic [DATA_W-1:0] instr_wr_data,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    LD_LEN_HI, LD_LEN_LO, LD_WORD_HI, LD_WORD_LO, LD_COMMIT, LD_DONE, LD_ERR
  } ld_state_t;

  // Serial receiver state
  logic             rx_meta, rx_sync;
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       rx_byte, rx_byte_nxt;
  logic             byte_valid, byte_valid_nxt;
  logic             stop_err, stop_err_nxt;

  // Loader state
  ld_state_t          ld_state, ld_state_nxt;
  logic [7:0]         len_hi, len_hi_nxt;
  logic [15:0]        len, len_nxt;
  logic [7:0]         word_hi, word_hi_nxt;
  logic [ADDR_W-1:0]  addr_cnt, addr_cnt_nxt;
  logic [15:0]        wr_count, wr_count_nxt;
  logic               wr_en_nxt;
  logic [ADDR_W-1:0]  wr_addr_nxt;
  logic [DATA_W-1:0]  wr_data_nxt;
  logic               frame_err_nxt;

  // Two-flop synchronizer; idles high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  // Receiver register bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      rx_state   <= rx_state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      rx_byte    <= rx_byte_nxt;
      byte_valid <= byte_valid_nxt;
      stop_err   <= stop_err_nxt;
    end
  end

  // Receiver next state. The start bit is re-checked at its midpoint so every
  // following sample lands mid-bit; a start bit that is gone by then is noise.
  always_comb begin
    rx_state_nxt   = rx_state;
    clk_cnt_nxt    = clk_cnt;
    bit_idx_nxt    = bit_idx;
    rx_byte_nxt    = rx_byte;
    byte_valid_nxt = 1'b0;
    stop_err_nxt   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          clk_cnt_nxt  = '0;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (clk_cnt == HALF_M1) begin
          clk_cnt_nxt  = '0;
          bit_idx_nxt  = '0;
          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_nxt = '0;
          rx_byte_nxt = {rx_sync, rx_byte[7:1]};
          if (bit_idx == 3'd7) begin
            rx_state_nxt = RX_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_nxt  = '0;
          rx_state_nxt = RX_IDLE;
          if (rx_sync) begin
            byte_valid_nxt = 1'b1;
          end else begin
            stop_err_nxt = 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Loader register bank. Status outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state      <= LD_LEN_HI;
      len_hi        <= '0;
      len           <= '0;
      word_hi       <= '0;
      addr_cnt      <= '0;
      wr_count      <= '0;
      instr_wr_en   <= 1'b0;
      instr_wr_addr <= '0;
      instr_wr_data <= '0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cpu_reset_n   <= 1'b0;
    end else begin
      ld_state      <= ld_state_nxt;
      len_hi        <= len_hi_nxt;
      len           <= len_nxt;
      word_hi       <= word_hi_nxt;
      addr_cnt      <= addr_cnt_nxt;
      wr_count      <= wr_count_nxt;
      instr_wr_en   <= wr_en_nxt;
      instr_wr_addr <= wr_addr_nxt;
      instr_wr_data <= wr_data_nxt;
      frame_err     <= frame_err_nxt;
      busy          <= (ld_state_nxt == LD_WORD_HI) || (ld_state_nxt == LD_WORD_LO) ||
                       (ld_state_nxt == LD_COMMIT);
      done          <= (ld_state_nxt == LD_DONE);
      cpu_reset_n   <= (ld_state_nxt == LD_DONE);
    end
  end

  // Loader next state. LD_COMMIT is the cycle the write strobe is on the bus;
  // it decides whether that was the last word.
  always_comb begin
    ld_state_nxt  = ld_state;
    len_hi_nxt    = len_hi;
    len_nxt       = len;
    word_hi_nxt   = word_hi;
    addr_cnt_nxt  = addr_cnt;
    wr_count_nxt  = wr_count;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = instr_wr_addr;
    wr_data_nxt   = instr_wr_data;
    frame_err_nxt = frame_err;
    case (ld_state)
      LD_LEN_HI: begin
        if (byte_valid) begin
          len_hi_nxt   = rx_byte;
          ld_state_nxt = LD_LEN_LO;
        end
      end
      LD_LEN_LO: begin
        if (byte_valid) begin
          len_nxt = {len_hi, rx_byte};
          if ({len_hi, rx_byte} == 16'd0) begin
            ld_state_nxt = LD_DONE;
          end else if ({1'b0, len_hi, rx_byte} > MAX_LEN) begin
            frame_err_nxt = 1'b1;
            ld_state_nxt  = LD_ERR;
          end else begin
            ld_state_nxt = LD_WORD_HI;
          end
        end
      end
      LD_WORD_HI: begin
        if (byte_valid) begin
          word_hi_nxt  = rx_byte;
          ld_state_nxt = LD_WORD_LO;
        end
      end
      LD_WORD_LO: begin
        if (byte_valid) begin
          wr_en_nxt    = 1'b1;
          wr_addr_nxt  = addr_cnt;
          wr_data_nxt  = {word_hi, rx_byte};
          addr_cnt_nxt = addr_cnt + 1'b1;
          ld_state_nxt = LD_COMMIT;
        end
      end
      LD_COMMIT: begin
        wr_count_nxt = wr_count + 16'd1;
        ld_state_nxt = (wr_count + 16'd1 == len) ? LD_DONE : LD_WORD_HI;
      end
      LD_DONE: ld_state_nxt = LD_DONE;
      LD_ERR:  ld_state_nxt = LD_ERR;
      default: ld_state_nxt = LD_ERR;
    endcase

    // A broken frame aborts the load from any state except DONE: once the
    // processor has been released, line noise must not pull it back into reset.
    if (stop_err && (ld_state != LD_DONE)) begin
      frame_err_nxt = 1'b1;
      wr_en_nxt     = 1'b0;
      ld_state_nxt  = LD_ERR;
    end
  end

endmodule

// File: tb/tb_instr_boot_loader.sv
// -----------------------------------------------------------------------------
// Self-checking bench for instr_boot_loader. Expected writes are queued as
// stimulus is sent and compared when the DUT strobes instr_wr_en.
// -----------------------------------------------------------------------------
module tb_instr_boot_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_in = 1'b1;
  logic        instr_wr_en;
  logic [12:0] instr_wr_addr;
  logic [15:0] instr_wr_data;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        frame_err;

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  int strobe_cnt = 0;
  int last_strobe_cycle = -1;
  int done_cycle = -1;
  int cpu_rel_cycle = -1;
  logic prev_wr_en = 1'b0;
  logic prev_done = 1'b0;
  logic prev_cpu = 1'b0;
  logic [28:0] exp_q[$];

  instr_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W(13),
    .DATA_W(16),
    .MAX_WORDS(8192)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_in(rx_in),
    .instr_wr_en(instr_wr_en),
    .instr_wr_addr(instr_wr_addr),
    .instr_wr_data(instr_wr_data),
    .cpu_reset_n(cpu_reset_n),
    .busy(busy),
    .done(done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Write monitor: every strobe is matched against the scoreboard.
  always @(negedge clk) begin
    logic [28:0] e;
    if (instr_wr_en) begin
      strobe_cnt++;
      last_strobe_cycle = cycle;
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_strobe: got addr=%0d data=%h, required no write",
                 instr_wr_addr, instr_wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({instr_wr_addr, instr_wr_data} !== e)
          $display("[TB] FAIL write_content: got addr=%0d data=%h, required addr=%0d data=%h",
                   instr_wr_addr, instr_wr_data, e[28:16], e[15:0]);
        else
          passes++;
      end
      if (prev_wr_en) begin
        checks++;
        $display("[TB] FAIL strobe_width: got 2+ cycles, required 1 cycle");
      end
    end
    if (done && !prev_done) done_cycle = cycle;
    if (cpu_reset_n && !prev_cpu) cpu_rel_cycle = cycle;
    prev_wr_en = instr_wr_en;
    prev_done = done;
    prev_cpu = cpu_reset_n;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got no completion, required completion before 2 ms");
    $fatal(1, "[TB] timeout");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int stop_cycle);
    @(negedge clk) rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop_bit;
    stop_cycle = cycle;
    repeat (CPB) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    done_cycle = -1;
    cpu_rel_cycle = -1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic cpu_held;
    int s0;
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (instr_wr_en !== 1'b0) $display("[TB] FAIL rst_wr_en: got %b required 0", instr_wr_en); else passes++;
    checks++; if (instr_wr_addr !== 13'd0) $display("[TB] FAIL rst_wr_addr: got %0d required 0", instr_wr_addr); else passes++;
    checks++; if (instr_wr_data !== 16'd0) $display("[TB] FAIL rst_wr_data: got %h required 0000", instr_wr_data); else passes++;
    checks++; if (cpu_reset_n !== 1'b0) $display("[TB] FAIL rst_cpu_reset_n: got %b required 0", cpu_reset_n); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b required 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rst_done: got %b required 0", done); else passes++;
    checks++; if (frame_err !== 1'b0) $display("[TB] FAIL rst_frame_err: got %b required 0", frame_err); else passes++;
    reset = 1'b1;
    s0 = strobe_cnt;
    cpu_held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cpu_reset_n !== 1'b0 || done !== 1'b0) cpu_held = 1'b0;
    end
    checks++; if (cpu_held !== 1'b1) $display("[TB] FAIL idle_cpu_held: got released, required held for 100 cycles"); else passes++;
    checks++; if (strobe_cnt != s0) $display("[TB] FAIL idle_strobes: got %0d required 0", strobe_cnt - s0); else passes++;
  endtask

  task automatic test_two_words();
    int s0, sc;
    s0 = strobe_cnt;
    done_cycle = -1;
    cpu_rel_cycle = -1;
    exp_q.push_back({13'd0, 16'h1234});
    exp_q.push_back({13'd1, 16'hABCD});
    send_byte(8'h00, 1'b1, sc);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL two_busy_pre: got %b required 0", busy); else passes++;
    send_byte(8'h02, 1'b1, sc);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL two_busy_hdr: got %b required 1", busy); else passes++;
    send_byte(8'h12, 1'b1, sc);
    send_byte(8'h34, 1'b1, sc);
    checks++; if (busy !== 1'b1 || done !== 1'b0) $display("[TB] FAIL two_busy_mid: got busy=%b done=%b required busy=1 done=0", busy, done); else passes++;
    send_byte(8'hAB, 1'b1, sc);
    send_byte(8'hCD, 1'b1, sc);
    repeat (10) @(negedge clk);
    checks++; if (strobe_cnt - s0 != 2) $display("[TB] FAIL two_strobe_count: got %0d required 2", strobe_cnt - s0); else passes++;
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL two_pending: got %0d pending required 0", exp_q.size()); else passes++;
    checks++; if (done_cycle != last_strobe_cycle + 1) $display("[TB] FAIL two_done_timing: got cycle %0d required %0d", done_cycle, last_strobe_cycle + 1); else passes++;
    checks++; if (cpu_rel_cycle != last_strobe_cycle + 1) $display("[TB] FAIL two_cpu_timing: got cycle %0d required %0d", cpu_rel_cycle, last_strobe_cycle + 1); else passes++;
    checks++; if (done !== 1'b1 || cpu_reset_n !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL two_final: got done=%b cpu=%b busy=%b required 1 1 0", done, cpu_reset_n, busy); else passes++;
    checks++; if (instr_wr_addr !== 13'd1) $display("[TB] FAIL two_addr_hold: got %0d required 1", instr_wr_addr); else passes++;
  endtask

  task automatic test_zero_len();
    int s0, sc;
    do_reset();
    s0 = strobe_cnt;
    send_byte(8'h00, 1'b1, sc);
    checks++; if (done !== 1'b0) $display("[TB] FAIL zero_done_early: got %b required 0", done); else passes++;
    send_byte(8'h00, 1'b1, sc);
    checks++; if (done !== 1'b1 || cpu_reset_n !== 1'b1) $display("[TB] FAIL zero_done: got done=%b cpu=%b required 1 1", done, cpu_reset_n); else passes++;
    checks++; if (done_cycle <= sc || done_cycle > sc + CPB) $display("[TB] FAIL zero_done_window: got cycle %0d required in (%0d,%0d]", done_cycle, sc, sc + CPB); else passes++;
    checks++; if (cpu_rel_cycle != done_cycle) $display("[TB] FAIL zero_cpu_timing: got cycle %0d required %0d", cpu_rel_cycle, done_cycle); else passes++;
    send_byte(8'h55, 1'b1, sc);
    send_byte(8'h66, 1'b1, sc);
    checks++; if (strobe_cnt != s0) $display("[TB] FAIL zero_strobes: got %0d required 0", strobe_cnt - s0); else passes++;
    checks++; if (done !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL zero_after: got done=%b busy=%b required 1 0", done, busy); else passes++;
  endtask

  task automatic test_stop_err();
    int s0, sc;
    do_reset();
    s0 = strobe_cnt;
    send_byte(8'h00, 1'b1, sc);
    send_byte(8'h01, 1'b1, sc);
    send_byte(8'h12, 1'b0, sc);
    checks++; if (frame_err !== 1'b1) $display("[TB] FAIL stop_frame_err: got %b required 1", frame_err); else passes++;
    checks++; if (cpu_reset_n !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL stop_state: got cpu=%b busy=%b required 0 0", cpu_reset_n, busy); else passes++;
    send_byte(8'h34, 1'b1, sc);
    send_byte(8'h56, 1'b1, sc);
    checks++; if (strobe_cnt != s0) $display("[TB] FAIL stop_strobes: got %0d required 0", strobe_cnt - s0); else passes++;
    checks++; if (done !== 1'b0 || cpu_reset_n !== 1'b0 || frame_err !== 1'b1) $display("[TB] FAIL stop_sticky: got done=%b cpu=%b ferr=%b required 0 0 1", done, cpu_reset_n, frame_err); else passes++;
  endtask

  task automatic test_glitch_oversize();
    int s0, sc;
    do_reset();
    s0 = strobe_cnt;
    @(negedge clk) rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    send_byte(8'h20, 1'b1, sc);
    checks++; if (frame_err !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL glitch_no_byte: got ferr=%b busy=%b required 0 0", frame_err, busy); else passes++;
    send_byte(8'h01, 1'b1, sc);
    checks++; if (frame_err !== 1'b1) $display("[TB] FAIL oversize_frame_err: got %b required 1", frame_err); else passes++;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cpu_reset_n !== 1'b0) $display("[TB] FAIL oversize_state: got busy=%b done=%b cpu=%b required 0 0 0", busy, done, cpu_reset_n); else passes++;
    send_byte(8'h00, 1'b1, sc);
    send_byte(8'h01, 1'b1, sc);
    send_byte(8'h11, 1'b1, sc);
    send_byte(8'h22, 1'b1, sc);
    checks++; if (strobe_cnt != s0 || done !== 1'b0) $display("[TB] FAIL oversize_locked: got strobes=%0d done=%b required 0 0", strobe_cnt - s0, done); else passes++;
  endtask

  task automatic test_reset_midload();
    int s0, sc;
    do_reset();
    s0 = strobe_cnt;
    exp_q.push_back({13'd0, 16'h1111});
    send_byte(8'h00, 1'b1, sc);
    send_byte(8'h03, 1'b1, sc);
    send_byte(8'h11, 1'b1, sc);
    send_byte(8'h11, 1'b1, sc);
    checks++; if (strobe_cnt - s0 != 1 || busy !== 1'b1) $display("[TB] FAIL mid_first_word: got strobes=%0d busy=%b required 1 1", strobe_cnt - s0, busy); else passes++;
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_wr_en !== 1'b0 || instr_wr_addr !== 13'd0 || instr_wr_data !== 16'd0 ||
        cpu_reset_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0)
      $display("[TB] FAIL mid_reset_values: got en=%b addr=%0d data=%h cpu=%b busy=%b done=%b ferr=%b required all 0",
               instr_wr_en, instr_wr_addr, instr_wr_data, cpu_reset_n, busy, done, frame_err);
    else passes++;
    reset = 1'b1;
    done_cycle = -1;
    cpu_rel_cycle = -1;
    repeat (2) @(negedge clk);
    s0 = strobe_cnt;
    exp_q.push_back({13'd0, 16'hBEEF});
    send_byte(8'h00, 1'b1, sc);
    send_byte(8'h01, 1'b1, sc);
    send_byte(8'hBE, 1'b1, sc);
    send_byte(8'hEF, 1'b1, sc);
    repeat (10) @(negedge clk);
    checks++; if (strobe_cnt - s0 != 1 || exp_q.size() != 0) $display("[TB] FAIL reload_strobes: got %0d pending=%0d required 1 0", strobe_cnt - s0, exp_q.size()); else passes++;
    checks++; if (done !== 1'b1 || cpu_reset_n !== 1'b1) $display("[TB] FAIL reload_done: got done=%b cpu=%b required 1 1", done, cpu_reset_n); else passes++;
    checks++; if (done_cycle != last_strobe_cycle + 1) $display("[TB] FAIL reload_done_timing: got cycle %0d required %0d", done_cycle, last_strobe_cycle + 1); else passes++;
  endtask

  initial begin
    $display("[TB] starting instr_boot_loader bench");
    test_reset();
    test_two_words();
    test_zero_len();
    test_stop_err();
    test_glitch_oversize();
    test_reset_midload();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
